// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard.
// Holds the default register index width, the producer latency type and the
// canonical latencies the decoder presents on id_lat.
package hazard_pkg;

  localparam int unsigned REG_W = 5;

  // Wide enough for the default MAX_LAT of 7.
  localparam int unsigned LAT_W = 3;
  typedef logic [LAT_W-1:0] lat_t;

  localparam lat_t LAT_ALU  = 3'd0;
  localparam lat_t LAT_LOAD = 3'd1;
  localparam lat_t LAT_MULT = 3'd3;

  localparam int unsigned BR_EXTRA_DEFAULT = 1;

endpackage

// File: rtl/hazard_cnt_cell.sv
// One per-register countdown of the hazard scoreboard.
// Ports:
//   clk, rst  pipeline clock, asynchronous active-high reset
//   load      the issuing instruction writes this register
//   lat       producer latency of the issuing instruction
//   cnt       current countdown value
// Every cycle the count decrements, saturating at 0. A load takes the larger of
// the decremented count and lat+BR_EXTRA, so a short write never shortens a
// pending long one (WAW).
module hazard_cnt_cell
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned LAT_W    = 3,
  parameter int unsigned BR_EXTRA = BR_EXTRA_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LAT_W-1:0] lat,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d, dec_val, ld_val;

  always_comb begin
    dec_val = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
    ld_val  = CNT_W'(lat) + CNT_W'(BR_EXTRA);
    cnt_d   = dec_val;
    if (load && (ld_val > dec_val)) cnt_d = ld_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use / multi-cycle hazard unit beside the ID stage.
// A per-register countdown records how many more cycles a dependent consumer
// must wait; the ID instruction stalls while any source it reads is still hot.
// Branches compare in ID, so they wait BR_EXTRA cycles longer than other ops.
// Ports:
//   clk, rst        pipeline clock, asynchronous active-high reset
//   id_valid        valid instruction in ID
//   id_src1/id_src2 rs / rt fields; id_src2_used qualifies rt
//   id_is_branch    ID-resolved branch (stricter threshold)
//   id_wb_en/id_dest/id_lat  destination write and its result latency
//   flush           kill the ID instruction (overrides stall, blocks the load)
//   stall           hold PC and IF/ID, bubble into ID/EX
//   stall_cycles    saturating count of stalled cycles (HAZARD_PERF_EN only)
// Build option: define HAZARD_PERF_EN to add the stall_cycles counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned REG_W    = hazard_pkg::REG_W,
  parameter int unsigned MAX_LAT  = 7,
  parameter int unsigned BR_EXTRA = BR_EXTRA_DEFAULT,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [REG_W-1:0]             id_src1,
  input  logic [REG_W-1:0]             id_src2,
  input  logic                         id_src2_used,
  input  logic                         id_is_branch,
  input  logic                         id_wb_en,
  input  logic [REG_W-1:0]             id_dest,
  input  logic [$clog2(MAX_LAT+1)-1:0] id_lat,
  input  logic                         flush,
  output logic                         stall
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]                  stall_cycles
`endif
);

  localparam int unsigned LAT_BITS = $clog2(MAX_LAT + 1);

  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [CNT_W-1:0] cnt_s1, cnt_s2, thr;
  logic             hazard, issue;

  // r0 is hardwired zero and never a dependency.
  assign cnt[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cell
    hazard_cnt_cell #(
      .CNT_W   (CNT_W),
      .LAT_W   (LAT_BITS),
      .BR_EXTRA(BR_EXTRA)
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .load(issue && id_wb_en && (id_dest == REG_W'(r))),
      .lat (id_lat),
      .cnt (cnt[r])
    );
  end

  always_comb begin
    cnt_s1 = cnt[id_src1];
    cnt_s2 = cnt[id_src2];
    // Non-branch consumers pick the result up via forwarding BR_EXTRA cycles
    // earlier than a branch comparing in ID can.
    thr    = id_is_branch ? '0 : CNT_W'(BR_EXTRA);
    hazard = (cnt_s1 > thr) || (id_src2_used && (cnt_s2 > thr));
    stall  = id_valid && !flush && hazard;
    issue  = id_valid && !stall && !flush;
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

  lat_legal_a: assert property (@(posedge clk) disable iff (rst)
                                id_valid |-> (id_lat <= LAT_BITS'(MAX_LAT)));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed hazard sequences plus a
// random run, with a reference countdown model and an expected-stall queue.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int unsigned BR = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_src1 = '0, id_src2 = '0, id_dest = '0;
  logic       id_src2_used = 1'b0, id_is_branch = 1'b0, id_wb_en = 1'b0;
  logic [2:0] id_lat = '0;
  logic       flush = 1'b0;
  logic       stall;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles;
`endif

  hazard_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_src2_used(id_src2_used),
    .id_is_branch(id_is_branch),
    .id_wb_en    (id_wb_en),
    .id_dest     (id_dest),
    .id_lat      (id_lat),
    .flush       (flush),
    .stall       (stall)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_bad = 0;
  logic exp_q[$];
  logic [3:0] m_cnt [32];
  int   m_perf = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_stall(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                                       input logic s2u, input logic br, input logic fl);
    logic [3:0] thr;
    thr = br ? 4'd0 : 4'(BR);
    return v && !fl && ((m_cnt[s1] > thr) || (s2u && (m_cnt[s2] > thr)));
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_cnt[r] = '0;
    m_perf = 0;
  endtask

  // Present one ID cycle, compare stall at the falling edge, advance the model.
  task automatic drive(input string tag, input logic v, input logic [4:0] s1,
                       input logic [4:0] s2, input logic s2u, input logic br, input logic wb,
                       input logic [4:0] dst, input logic [2:0] lat, input logic fl,
                       output logic got);
    logic       e, iss;
    logic [3:0] dec, ldv;
    id_valid = v; id_src1 = s1; id_src2 = s2; id_src2_used = s2u; id_is_branch = br;
    id_wb_en = wb; id_dest = dst; id_lat = lat; flush = fl;
    e = model_stall(v, s1, s2, s2u, br, fl);
    exp_q.push_back(e);
    @(negedge clk);
    got = stall;
    check_eq(tag, {31'b0, stall}, {31'b0, exp_q.pop_front()});
    iss = v && !e && !fl;
    ldv = 4'(lat) + 4'(BR);
    for (int r = 1; r < 32; r++) begin
      dec = (m_cnt[r] == 0) ? 4'd0 : m_cnt[r] - 4'd1;
      if (iss && wb && (dst == 5'(r)) && (ldv > dec)) m_cnt[r] = ldv;
      else m_cnt[r] = dec;
    end
    if (e) m_perf++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    logic g;
    drive("idle", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, g);
  endtask

  task automatic produce(input string tag, input logic [4:0] dst, input logic [2:0] lat);
    logic g;
    drive(tag, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, dst, lat, 1'b0, g);
  endtask

  // Hold a consumer in ID until the DUT releases it; compare the stall count.
  task automatic consume(input string tag, input logic [4:0] s1, input logic [4:0] s2,
                         input logic s2u, input logic br, input logic [4:0] dst,
                         input int exp_stalls);
    logic g;
    int   n;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      drive(tag, 1'b1, s1, s2, s2u, br, 1'b1, dst, LAT_ALU, 1'b0, g);
      if (!g) break;
      n++;
    end
    check_eq({tag, "_stalls"}, n, exp_stalls);
  endtask

  initial begin
    logic g;
    model_reset();
    // Reset state: a valid consumer during reset must not stall.
    id_valid = 1'b1; id_src1 = 5'd1;
    #3;
    check_eq("reset_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Load-use: ALU consumer 1 stall, branch consumer 1+BR stalls.
    produce("lw_r8", 5'd8, LAT_LOAD);
    consume("ld_alu", 5'd8, 5'd1, 1'b1, 1'b0, 5'd9, 1);
    produce("lw_r8b", 5'd8, LAT_LOAD);
    consume("ld_br", 5'd8, 5'd0, 1'b1, 1'b1, 5'd0, 1 + BR);

    // ALU producer: branch stalls BR cycles, non-branch none.
    produce("add_r3", 5'd3, LAT_ALU);
    consume("alu_br", 5'd3, 5'd4, 1'b1, 1'b1, 5'd0, BR);
    produce("add_r3b", 5'd3, LAT_ALU);
    consume("alu_alu", 5'd3, 5'd0, 1'b0, 1'b0, 5'd5, 0);

    // WAW: a later short write must not shorten the pending mult.
    produce("mult_r2", 5'd2, LAT_MULT);
    produce("add_r2", 5'd2, LAT_ALU);
    consume("waw", 5'd2, 5'd0, 1'b0, 1'b0, 5'd6, 2);

    // r0 and unused rt never stall.
    produce("lw_r0", 5'd0, LAT_LOAD);
    consume("r0_src", 5'd0, 5'd0, 1'b1, 1'b0, 5'd1, 0);
    produce("lw_r7", 5'd7, LAT_LOAD);
    consume("rt_unused", 5'd2, 5'd7, 1'b0, 1'b0, 5'd1, 0);

    // Flush beats stall and loads nothing.
    produce("lw_r10", 5'd10, LAT_LOAD);
    drive("flush_dep", 1'b1, 5'd10, 5'd0, 1'b0, 1'b0, 1'b1, 5'd11, LAT_MULT, 1'b1, g);
    check_eq("flush_no_stall", {31'b0, g}, 32'd0);
    consume("flush_noload", 5'd11, 5'd0, 1'b1, 1'b1, 5'd0, 0);

    // Asynchronous reset mid-countdown with cnt[5]=3.
    produce("mult_r5", 5'd5, LAT_MULT);
    idle();
    id_valid = 1'b1; id_src1 = 5'd5; id_src2_used = 1'b0; id_is_branch = 1'b0;
    id_wb_en = 1'b0; flush = 1'b0;
    #1;
    check_eq("pre_rst_stall", {31'b0, stall}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_async", {31'b0, stall}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check_eq("rst_held", {31'b0, stall}, 32'd0);
`ifdef HAZARD_PERF_EN
    check_eq("perf_rst", stall_cycles, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    consume("rst_consumer", 5'd5, 5'd0, 1'b0, 1'b0, 5'd12, 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive("rand", ($urandom_range(0, 9) != 0), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 9) == 0), g);
    end

`ifdef HAZARD_PERF_EN
    check_eq("perf_count", stall_cycles, 32'(m_perf));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
